// File: rtl/gpio_pkg.sv
// Register map shared by the GPIO peripheral and its users.
// Pure definitions, so there is no latency and no flow control.
package gpio_pkg;

   localparam logic [4:0] MODER_OFS = 5'h00;
   localparam logic [4:0] IDR_OFS   = 5'h04;
   localparam logic [4:0] ODR_OFS   = 5'h08;
   localparam logic [4:0] BSRR_OFS  = 5'h0C;
   localparam logic [4:0] IER_OFS   = 5'h10;
   localparam logic [4:0] RTSR_OFS  = 5'h14;
   localparam logic [4:0] FTSR_OFS  = 5'h18;
   localparam logic [4:0] ISR_OFS   = 5'h1C;

   localparam int BSRR_RESET_SHIFT = 16;

   typedef enum logic [2:0] {
      SEL_MODER = 3'd0,
      SEL_IDR   = 3'd1,
      SEL_ODR   = 3'd2,
      SEL_BSRR  = 3'd3,
      SEL_IER   = 3'd4,
      SEL_RTSR  = 3'd5,
      SEL_FTSR  = 3'd6,
      SEL_ISR   = 3'd7
   } reg_sel_e;

endpackage

// File: rtl/gpio_irq_if.sv
// Data-memory bus slice seen by the GPIO peripheral.
// Single-cycle access with a combinational read path and no stall signal.
interface gpio_irq_if #(
   parameter int ADDR_W = 5
);
   logic              ce;
   logic              wr_en;
   logic [ADDR_W-1:0] addr;
   logic [31:0]       wdata;
   logic [31:0]       rdata;

   modport master (output ce, output wr_en, output addr, output wdata, input rdata);
   modport slave  (input ce, input wr_en, input addr, input wdata, output rdata);
endinterface

// File: rtl/gpio_sync_edge.sv
// Pad synchroniser chain plus a one-deep history register for edge detection.
// The IDR lags the pad by SYNC_STAGES edges; it is free-running with no backpressure.
module gpio_sync_edge #(
   parameter int WIDTH       = 16,
   parameter int SYNC_STAGES = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] pad_i,
   output logic [WIDTH-1:0] idr_o,
   output logic [WIDTH-1:0] rise_o,
   output logic [WIDTH-1:0] fall_o
);
   // Stage 0 captures the pad; the last stage is the architectural IDR.
   logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q, sync_d;
   logic [WIDTH-1:0]                  prev_q, prev_d;

   always_comb begin
      sync_d = {sync_q[SYNC_STAGES-2:0], pad_i};
      prev_d = sync_q[SYNC_STAGES-1];
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         sync_q <= '0;
         prev_q <= '0;
      end else begin
         sync_q <= sync_d;
         prev_q <= prev_d;
      end
   end

   assign idr_o  = sync_q[SYNC_STAGES-1];
   assign rise_o = sync_q[SYNC_STAGES-1] & ~prev_q;
   assign fall_o = ~sync_q[SYNC_STAGES-1] & prev_q;

endmodule

// File: rtl/gpio_irq.sv
// Memory-mapped GPIO with per-pin direction, BSRR set/clear and sticky edge interrupts.
// Writes land on the clk edge; reads and irq are combinational; the bus is never stalled.
module gpio_irq
   import gpio_pkg::*;
#(
   parameter int WIDTH       = 16,
   parameter int SYNC_STAGES = 2,
   parameter int ADDR_W      = 5
) (
   input  logic             clk,
   input  logic             reset,
   gpio_irq_if.slave        bus,
   output logic             irq,
   inout  wire  [WIDTH-1:0] IOPort
);
   logic [WIDTH-1:0]  moder_q, moder_d, odr_q, odr_d, ier_q, ier_d;
   logic [WIDTH-1:0]  rtsr_q, rtsr_d, ftsr_q, ftsr_d, isr_q, isr_d;
   logic [WIDTH-1:0]  idr, rise, fall, wr_val, bsrr_set, bsrr_clr, rd_val;
   logic [ADDR_W-1:0] addr;
   reg_sel_e          sel;
   logic              wr_stb, rd_stb;
   logic              unused_bus;

   assign addr       = bus.addr;
   assign sel        = reg_sel_e'(addr[4:2]);
   assign wr_stb     = bus.ce & bus.wr_en;
   assign rd_stb     = bus.ce & ~bus.wr_en;
   assign wr_val     = bus.wdata[WIDTH-1:0];
   assign bsrr_set   = bus.wdata[WIDTH-1:0];
   assign bsrr_clr   = bus.wdata[BSRR_RESET_SHIFT +: WIDTH];
   assign unused_bus = ^{addr, bus.wdata};

   gpio_sync_edge #(
      .WIDTH       (WIDTH),
      .SYNC_STAGES (SYNC_STAGES)
   ) u_sync_edge (
      .clk    (clk),
      .reset  (reset),
      .pad_i  (IOPort),
      .idr_o  (idr),
      .rise_o (rise),
      .fall_o (fall)
   );

   always_comb begin
      moder_d = moder_q;
      odr_d   = odr_q;
      ier_d   = ier_q;
      rtsr_d  = rtsr_q;
      ftsr_d  = ftsr_q;
      isr_d   = isr_q;
      if (wr_stb) begin
         case (sel)
            SEL_MODER: moder_d = wr_val;
            SEL_ODR:   odr_d   = wr_val;
            SEL_BSRR:  odr_d   = (odr_q & ~bsrr_clr) | bsrr_set;
            SEL_IER:   ier_d   = wr_val;
            SEL_RTSR:  rtsr_d  = wr_val;
            SEL_FTSR:  ftsr_d  = wr_val;
            SEL_ISR:   isr_d   = isr_q & ~wr_val;
            default:   ;
         endcase
      end
      // Applied after the W1C so a coincident qualifying edge keeps its bit pending.
      isr_d = isr_d | (rise & rtsr_q) | (fall & ftsr_q);
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         moder_q <= '0;
         odr_q   <= '0;
         ier_q   <= '0;
         rtsr_q  <= '0;
         ftsr_q  <= '0;
         isr_q   <= '0;
      end else begin
         moder_q <= moder_d;
         odr_q   <= odr_d;
         ier_q   <= ier_d;
         rtsr_q  <= rtsr_d;
         ftsr_q  <= ftsr_d;
         isr_q   <= isr_d;
      end
   end

   always_comb begin
      rd_val = '0;
      if (rd_stb) begin
         case (sel)
            SEL_MODER: rd_val = moder_q;
            SEL_IDR:   rd_val = idr;
            SEL_ODR:   rd_val = odr_q;
            SEL_BSRR:  rd_val = '0;
            SEL_IER:   rd_val = ier_q;
            SEL_RTSR:  rd_val = rtsr_q;
            SEL_FTSR:  rd_val = ftsr_q;
            SEL_ISR:   rd_val = isr_q;
            default:   rd_val = '0;
         endcase
      end
   end

   always_comb begin
      bus.rdata              = '0;
      bus.rdata[WIDTH-1:0]   = rd_val;
   end

   assign irq = |(isr_q & ier_q);

   for (genvar i = 0; i < WIDTH; i++) begin : g_pad
      assign IOPort[i] = moder_q[i] ? odr_q[i] : 1'bz;
   end

endmodule
